// File: rtl/ahb_matrix_input_stage.sv
// ============================================================================
// Module   : ahb_matrix_input_stage
// Purpose  : AHB bus-matrix input stage. Passes the upstream master's address
//            phase straight to the decoder while the output stage has granted
//            this port. If a new transfer arrives while the port is not
//            granted, the transfer is captured into a holding register. The
//            upstream master is then stalled until the decoder reports the
//            port active and the held transfer has been issued.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   HCLK, HRESET          clock, asynchronous active-high reset
//   HSELS..HPROTS         upstream address-phase signals
//   HREADYS               bus HREADY seen by the upstream master
//   HREADYOUTS, HRESPS    ready/response returned to the upstream master
//   *_dec outputs         address phase + HREADY presented to the decoder
//   active_dec            output stage currently grants this port
//   readyout_dec/resp_dec selected slave ready/response from the decoder
// ============================================================================
`default_nettype none

module ahb_matrix_input_stage (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic        sel_dec,
  output logic [31:0] addr_dec,
  output logic [1:0]  trans_dec,
  output logic        write_dec,
  output logic [2:0]  size_dec,
  output logic [2:0]  burst_dec,
  output logic [3:0]  prot_dec,
  output logic        ready_dec,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic [1:0]  resp_dec
);

  typedef enum logic [0:0] {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] C_RESP_OKAY    = 2'b00;

  state_t      state_q, state_d;
  logic        dphase_q, dphase_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  burst_q, burst_d;
  logic [3:0]  prot_q, prot_d;

  logic        new_trans;

  assign new_trans = HSELS & HREADYS & HTRANSS[1];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dphase_d = dphase_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    burst_d  = burst_q;
    prot_d   = prot_q;

    case (state_q)
      PASS: begin
        if (new_trans && !active_dec) begin
          // Port not granted: park the transfer. The decoder did not accept
          // it, so no data phase starts on this edge.
          state_d  = HOLD;
          dphase_d = 1'b0;
          addr_d   = HADDRS;
          write_d  = HWRITES;
          size_d   = HSIZES;
          burst_d  = HBURSTS;
          prot_d   = HPROTS;
        end else if (HREADYS) begin
          // In PASS the decoder sees the live bus, so the data-phase flag
          // tracks what the decoder sampled.
          dphase_d = HSELS & HTRANSS[1];
        end
      end
      HOLD: begin
        // Held transfer is issued on the cycle the port becomes active.
        if (active_dec) begin
          state_d  = PASS;
          dphase_d = 1'b1;
        end
      end
      default: begin
        state_d  = PASS;
        dphase_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= PASS;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      burst_q  <= '0;
      prot_q   <= '0;
    end else begin
      state_q  <= state_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      prot_q   <= prot_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode: all selection is from registered state, so outputs only
  // change with HCLK (or reset) apart from the intended pass-through paths.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_dec    = HSELS;
    addr_dec   = HADDRS;
    trans_dec  = HTRANSS;
    write_dec  = HWRITES;
    size_dec   = HSIZES;
    burst_dec  = HBURSTS;
    prot_dec   = HPROTS;
    ready_dec  = HREADYS;
    HREADYOUTS = 1'b1;
    HRESPS     = C_RESP_OKAY;

    if (state_q == HOLD) begin
      // A captured SEQ is replayed as NONSEQ: the decoder/slave never saw
      // the preceding beat of the burst through this path.
      sel_dec    = 1'b1;
      addr_dec   = addr_q;
      trans_dec  = C_TRANS_NONSEQ;
      write_dec  = write_q;
      size_dec   = size_q;
      burst_dec  = burst_q;
      prot_dec   = prot_q;
      ready_dec  = 1'b1;
      HREADYOUTS = 1'b0;
    end else if (dphase_q) begin
      HREADYOUTS = readyout_dec;
      HRESPS     = resp_dec;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_matrix_input_stage.sv
// ============================================================================
// Module   : tb_ahb_matrix_input_stage
// Purpose  : Directed self-checking bench for ahb_matrix_input_stage.
//            Upstream HREADYS is tied to HREADYOUTS (single master on the
//            slave port). Inputs change 1 ns after the rising edge; outputs
//            are checked 5 ns after the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_matrix_input_stage;

  logic        HCLK;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        sel_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic        write_dec;
  logic [2:0]  size_dec;
  logic [2:0]  burst_dec;
  logic [3:0]  prot_dec;
  logic        ready_dec;
  logic        active_dec;
  logic        readyout_dec;
  logic [1:0]  resp_dec;

  int tests_run = 0;
  int tests_failed = 0;

  assign HREADYS = HREADYOUTS;

  ahb_matrix_input_stage dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSELS        (HSELS),
    .HADDRS       (HADDRS),
    .HTRANSS      (HTRANSS),
    .HWRITES      (HWRITES),
    .HSIZES       (HSIZES),
    .HBURSTS      (HBURSTS),
    .HPROTS       (HPROTS),
    .HREADYS      (HREADYS),
    .HREADYOUTS   (HREADYOUTS),
    .HRESPS       (HRESPS),
    .sel_dec      (sel_dec),
    .addr_dec     (addr_dec),
    .trans_dec    (trans_dec),
    .write_dec    (write_dec),
    .size_dec     (size_dec),
    .burst_dec    (burst_dec),
    .prot_dec     (prot_dec),
    .ready_dec    (ready_dec),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSELS        = 1'b0;
    HADDRS       = 32'h0;
    HTRANSS      = 2'b00;
    HWRITES      = 1'b0;
    HSIZES       = 3'd0;
    HBURSTS      = 3'd0;
    HPROTS       = 4'd0;
    active_dec   = 1'b1;
    readyout_dec = 1'b1;
    resp_dec     = 2'b00;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    HRESET = 1'b1;
    bus_idle();
    HSELS  = 1'b1;
    HADDRS = 32'h0000_00AC;
    #3;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_outputs: readyout=%b resp=%b, want 1/00", HREADYOUTS, HRESPS);
    end
    tests_run++;
    if (sel_dec !== 1'b1 || addr_dec !== 32'h0000_00AC) begin
      tests_failed++;
      $display("FAIL reset_passthru: sel=%b addr=%h, want 1/000000ac", sel_dec, addr_dec);
    end
    step();
    step();
    HRESET = 1'b0;
    bus_idle();
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || sel_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: readyout=%b sel=%b, want 1/0", HREADYOUTS, sel_dec);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_passthrough();
    step();
    HSELS = 1'b1; HADDRS = 32'h0000_0040; HTRANSS = 2'b10; HWRITES = 1'b0;
    active_dec = 1'b1; readyout_dec = 1'b1;
    #4;
    tests_run++;
    if (addr_dec !== 32'h0000_0040 || trans_dec !== 2'b10 || sel_dec !== 1'b1 || ready_dec !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_addr: addr=%h trans=%b sel=%b rdy=%b, want 00000040/10/1/1",
               addr_dec, trans_dec, sel_dec, ready_dec);
    end
    step();
    bus_idle();
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || sel_dec !== 1'b0 || trans_dec !== 2'b00) begin
      tests_failed++;
      $display("FAIL pass_dphase: readyout=%b sel=%b trans=%b, want 1/0/00",
               HREADYOUTS, sel_dec, trans_dec);
    end
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hold();
    int waits;
    waits = 0;
    HSELS = 1'b1; HADDRS = 32'h0000_1000; HTRANSS = 2'b10; HWRITES = 1'b1;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'd3; active_dec = 1'b0;
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_capture_cycle: readyout=%b, want 1", HREADYOUTS);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      // Upstream garbage must be ignored while holding.
      HSELS = 1'b0; HADDRS = 32'hDEAD_BEEF; HTRANSS = 2'b00; HWRITES = 1'b0;
      HSIZES = 3'd0; HPROTS = 4'd0;
      active_dec = (i == 4);
      #4;
      if (HREADYOUTS === 1'b0) waits++;
      tests_run++;
      if (addr_dec !== 32'h0000_1000 || trans_dec !== 2'b10 || sel_dec !== 1'b1 ||
          write_dec !== 1'b1 || size_dec !== 3'd2 || prot_dec !== 4'd3 || ready_dec !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_outputs[%0d]: addr=%h trans=%b sel=%b wr=%b size=%0d prot=%0d rdy=%b",
                 i, addr_dec, trans_dec, sel_dec, write_dec, size_dec, prot_dec, ready_dec);
      end
    end
    tests_run++;
    if (waits !== 4) begin
      tests_failed++;
      $display("FAIL hold_wait_count: waits=%0d, want 4", waits);
    end
    step();
    bus_idle();
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || sel_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_dphase_done: readyout=%b sel=%b, want 1/0", HREADYOUTS, sel_dec);
    end
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_seq_converted();
    HSELS = 1'b1; HADDRS = 32'h0000_2000; HTRANSS = 2'b11; active_dec = 1'b0;
    step();
    #4;
    tests_run++;
    if (trans_dec !== 2'b10 || addr_dec !== 32'h0000_2000 || HREADYOUTS !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_hold: trans=%b addr=%h readyout=%b, want 10/00002000/0",
               trans_dec, addr_dec, HREADYOUTS);
    end
    step();
    active_dec = 1'b1;
    #4;
    tests_run++;
    if (trans_dec !== 2'b10 || HREADYOUTS !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_issue: trans=%b readyout=%b, want 10/0", trans_dec, HREADYOUTS);
    end
    step();
    bus_idle();
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || sel_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL seq_dphase: readyout=%b sel=%b, want 1/0", HREADYOUTS, sel_dec);
    end
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_no_hold_cases();
    logic [1:0] tr [3];
    logic       sl [3];
    tr[0] = 2'b00; sl[0] = 1'b1;   // IDLE
    tr[1] = 2'b01; sl[1] = 1'b1;   // BUSY
    tr[2] = 2'b10; sl[2] = 1'b0;   // NONSEQ, not selected
    for (int k = 0; k < 3; k++) begin
      HSELS = sl[k]; HTRANSS = tr[k]; HADDRS = 32'h0000_7000; active_dec = 1'b0;
      #4;
      tests_run++;
      if (sel_dec !== sl[k] || trans_dec !== tr[k]) begin
        tests_failed++;
        $display("FAIL nohold_live[%0d]: sel=%b trans=%b, want %b/%b", k, sel_dec, trans_dec, sl[k], tr[k]);
      end
      step();
      bus_idle();
      active_dec = 1'b0;
      #4;
      tests_run++;
      if (sel_dec !== 1'b0 || HREADYOUTS !== 1'b1) begin
        tests_failed++;
        $display("FAIL nohold_next[%0d]: sel=%b readyout=%b, want 0/1", k, sel_dec, HREADYOUTS);
      end
      step();
    end
    bus_idle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_error();
    HSELS = 1'b1; HADDRS = 32'h0000_3000; HTRANSS = 2'b10; active_dec = 1'b1;
    step();
    bus_idle();
    resp_dec = 2'b01; readyout_dec = 1'b0;
    #4;
    tests_run++;
    if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b0 || ready_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cycle1: resp=%b readyout=%b rdy=%b, want 01/0/0", HRESPS, HREADYOUTS, ready_dec);
    end
    step();
    resp_dec = 2'b01; readyout_dec = 1'b1;
    #4;
    tests_run++;
    if (HRESPS !== 2'b01 || HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_cycle2: resp=%b readyout=%b, want 01/1", HRESPS, HREADYOUTS);
    end
    step();
    // No data phase now: decoder response must be masked to OKAY.
    resp_dec = 2'b01; readyout_dec = 1'b0;
    #4;
    tests_run++;
    if (HRESPS !== 2'b00 || HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_masked: resp=%b readyout=%b, want 00/1", HRESPS, HREADYOUTS);
    end
    bus_idle();
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wait_states();
    HSELS = 1'b1; HADDRS = 32'h0000_0040; HTRANSS = 2'b10; active_dec = 1'b1;
    step();
    HADDRS = 32'h0000_0044; readyout_dec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      tests_run++;
      if (HREADYOUTS !== 1'b0 || ready_dec !== 1'b0 || addr_dec !== 32'h0000_0044) begin
        tests_failed++;
        $display("FAIL wait[%0d]: readyout=%b rdy=%b addr=%h, want 0/0/00000044",
                 i, HREADYOUTS, ready_dec, addr_dec);
      end
      step();
    end
    readyout_dec = 1'b1;
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || ready_dec !== 1'b1 || addr_dec !== 32'h0000_0044) begin
      tests_failed++;
      $display("FAIL wait_ready: readyout=%b rdy=%b addr=%h, want 1/1/00000044",
               HREADYOUTS, ready_dec, addr_dec);
    end
    step();
    bus_idle();
    readyout_dec = 1'b0;
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b0 || sel_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_next_dphase: readyout=%b sel=%b, want 0/0", HREADYOUTS, sel_dec);
    end
    step();
    readyout_dec = 1'b1;
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_next_done: readyout=%b, want 1", HREADYOUTS);
    end
    step();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_hold();
    HSELS = 1'b1; HADDRS = 32'h0000_5000; HTRANSS = 2'b10; active_dec = 1'b0;
    step();
    HSELS = 1'b0; HADDRS = 32'h0000_6000; HTRANSS = 2'b00;
    #2;
    tests_run++;
    if (HREADYOUTS !== 1'b0 || sel_dec !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_hold_entered: readyout=%b sel=%b, want 0/1", HREADYOUTS, sel_dec);
    end
    #1;
    HRESET = 1'b1;
    #1;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || HRESPS !== 2'b00 || sel_dec !== 1'b0 || addr_dec !== 32'h0000_6000) begin
      tests_failed++;
      $display("FAIL rst_async: readyout=%b resp=%b sel=%b addr=%h, want 1/00/0/00006000",
               HREADYOUTS, HRESPS, sel_dec, addr_dec);
    end
    step();
    HRESET = 1'b0;
    bus_idle();
    active_dec = 1'b0;
    #4;
    tests_run++;
    if (HREADYOUTS !== 1'b1 || sel_dec !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_after: readyout=%b sel=%b, want 1/0", HREADYOUTS, sel_dec);
    end
    step();
    bus_idle();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_passthrough();
    test_hold();
    test_seq_converted();
    test_no_hold_cases();
    test_error();
    test_wait_states();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
